// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges the integer pipe, the mul/div unit and the FPU
// onto the single register-file write port. The mul and fpu results each wait
// in a one-entry holding register. When both are held, a round-robin pointer
// picks between them. A held entry that keeps losing to the integer pipe stalls
// that pipe until the entry is written.
// Optional feature macro: WB_PERF_EN adds the perf_stall_cnt,
// perf_conflict_cnt and perf_x0_drop_cnt output counters.
module writeback_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            int_valid,
  input  logic [4:0]      int_rd,
  input  logic [XLEN-1:0] int_data,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic [4:0]      mul_rd,
  input  logic [XLEN-1:0] mul_data,
  input  logic            fpu_valid,
  output logic            fpu_ready,
  input  logic [4:0]      fpu_rd,
  input  logic [XLEN-1:0] fpu_data,
  input  logic            fpu_to_fpr,
  output logic            stall_int,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
  output logic            reg_write,
  output logic            FPR_GPR_sel
`ifdef WB_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_conflict_cnt,
  output logic [31:0]     perf_x0_drop_cnt
`endif
);

  localparam int WW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

  // Entry index 0 is mul/div and entry index 1 is the FPU.
  logic [1:0]            in_valid;
  logic [1:0][4:0]       in_rd;
  logic [1:0][XLEN-1:0]  in_data;
  logic [1:0]            in_fpr;

  logic [1:0]            full;
  logic [1:0][4:0]       ent_rd;
  logic [1:0][XLEN-1:0]  ent_data;
  logic [1:0]            ent_fpr;
  logic [1:0][WW-1:0]    wait_next;

  logic                  ptr_reg;     // 0 = mul is next, 1 = fpu is next
  logic                  int_grant;
  logic [1:0]            ent_grant;
  logic                  any_grant;
  logic                  x0_drop;
  logic [4:0]            win_rd;
  logic [XLEN-1:0]       win_data;
  logic                  win_fpr;

  assign in_valid = {fpu_valid, mul_valid};
  assign in_rd    = {fpu_rd, mul_rd};
  assign in_data  = {fpu_data, mul_data};
  assign in_fpr   = {fpu_to_fpr, 1'b0};   // mul results always target the GPR file

  // Ready depends only on the stored occupancy, never on the incoming valid.
  assign mul_ready = ~full[0];
  assign fpu_ready = ~full[1];

  // Grant selection: an unstalled int result wins, then the held entries (round robin).
  always_comb begin
    int_grant = int_valid && !stall_int;
    ent_grant = 2'b00;
    if (!int_grant) begin
      if (full == 2'b11) begin
        ent_grant = ptr_reg ? 2'b10 : 2'b01;
      end else begin
        ent_grant = full;
      end
    end
  end

  // Winner data mux feeding the output register.
  always_comb begin
    win_rd   = int_rd;
    win_data = int_data;
    win_fpr  = 1'b0;
    if (ent_grant[1]) begin
      win_rd   = ent_rd[1];
      win_data = ent_data[1];
      win_fpr  = ent_fpr[1];
    end else if (ent_grant[0]) begin
      win_rd   = ent_rd[0];
      win_data = ent_data[0];
      win_fpr  = ent_fpr[0];
    end
  end

  assign any_grant = int_grant || (ent_grant != 2'b00);
  // A GPR write to x0 consumes the grant but never reaches the register file.
  assign x0_drop   = any_grant && !win_fpr && (win_rd == 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic            full_reg;
      logic [4:0]      rd_reg;
      logic [XLEN-1:0] data_reg;
      logic            fpr_reg;
      logic [WW-1:0]   wait_reg;
      logic [WW-1:0]   wait_calc;

      // Wait counter: counts lost cycles while held, saturating; clears when empty or granted.
      always_comb begin
        wait_calc = '0;
        if (full_reg && !ent_grant[gi]) begin
          wait_calc = (wait_reg < LIMIT) ? wait_reg + WW'(1) : wait_reg;
        end
      end

      // Holding register: frees on grant, captures on valid while empty.
      always_ff @(posedge clk) begin
        if (rst) begin
          full_reg <= 1'b0;
          rd_reg   <= '0;
          data_reg <= '0;
          fpr_reg  <= 1'b0;
          wait_reg <= '0;
        end else begin
          if (ent_grant[gi]) begin
            full_reg <= 1'b0;
          end else if (in_valid[gi] && !full_reg) begin
            full_reg <= 1'b1;
            rd_reg   <= in_rd[gi];
            data_reg <= in_data[gi];
            fpr_reg  <= in_fpr[gi];
          end
          wait_reg <= wait_calc;
        end
      end

      assign full[gi]      = full_reg;
      assign ent_rd[gi]    = rd_reg;
      assign ent_data[gi]  = data_reg;
      assign ent_fpr[gi]   = fpr_reg;
      assign wait_next[gi] = wait_calc;
    end
  endgenerate

  // Stall mirrors the saturated counters, so it drops at the same edge the starved entry is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_int <= 1'b0;
    end else begin
      stall_int <= (wait_next[0] >= LIMIT) || (wait_next[1] >= LIMIT);
    end
  end

  // Round-robin pointer moves to the other entry after an entry grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else if (ent_grant[0]) begin
      ptr_reg <= 1'b1;
    end else if (ent_grant[1]) begin
      ptr_reg <= 1'b0;
    end
  end

  // Output register: one cycle after the grant; the address/data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write   <= 1'b0;
      write_reg   <= '0;
      write_data  <= '0;
      FPR_GPR_sel <= 1'b0;
    end else begin
      reg_write <= any_grant && !x0_drop;
      if (any_grant && !x0_drop) begin
        write_reg   <= win_rd;
        write_data  <= win_data;
        FPR_GPR_sel <= win_fpr;
      end
    end
  end

`ifdef WB_PERF_EN
  logic conflict;
  assign conflict = (int_valid && full[0]) || (int_valid && full[1]) || (full[0] && full[1]);

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt    <= '0;
      perf_conflict_cnt <= '0;
      perf_x0_drop_cnt  <= '0;
    end else begin
      if (stall_int) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (conflict)  perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (x0_drop)   perf_x0_drop_cnt <= perf_x0_drop_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Flags an int result offered while the pipe is stalled; that result is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(int_valid && stall_int))
        else $error("writeback_arbiter: int_valid asserted while stall_int is high");
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed test of writeback_arbiter with hand-computed expectations.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_valid;
  logic [4:0]  int_rd;
  logic [31:0] int_data;
  logic        mul_valid;
  logic        mul_ready;
  logic [4:0]  mul_rd;
  logic [31:0] mul_data;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        fpu_to_fpr;
  logic        stall_int;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic        FPR_GPR_sel;
`ifdef WB_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_conflict_cnt;
  logic [31:0] perf_x0_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  writeback_arbiter #(.STARVE_LIMIT(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .int_valid(int_valid), .int_rd(int_rd), .int_data(int_data),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rd(mul_rd), .mul_data(mul_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_data(fpu_data),
    .fpu_to_fpr(fpu_to_fpr), .stall_int(stall_int),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .FPR_GPR_sel(FPR_GPR_sel)
`ifdef WB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_conflict_cnt(perf_conflict_cnt),
    .perf_x0_drop_cnt(perf_x0_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  initial begin
    rst = 1'b1; int_valid = 0; int_rd = 0; int_data = 0;
    mul_valid = 0; mul_rd = 0; mul_data = 0;
    fpu_valid = 0; fpu_rd = 0; fpu_data = 0; fpu_to_fpr = 0;
    step();
    step();
    // Reset state
    check("rst_reg_write", {31'd0, reg_write}, 32'd0);
    check("rst_write_reg", {27'd0, write_reg}, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_sel", {31'd0, FPR_GPR_sel}, 32'd0);
    check("rst_stall", {31'd0, stall_int}, 32'd0);
    check("rst_ready", {30'd0, mul_ready, fpu_ready}, 32'd3);
    $display("txn reset done");
    rst = 1'b0;

    // Single integer write
    int_valid = 1; int_rd = 5'd5; int_data = 32'h1234;
    step();
    int_valid = 0;
    check("int_we", {31'd0, reg_write}, 32'd1);
    check("int_reg", {27'd0, write_reg}, 32'd5);
    check("int_data", write_data, 32'h1234);
    check("int_sel", {31'd0, FPR_GPR_sel}, 32'd0);
    $display("txn int rd=5 data=0x1234 we=%0d", reg_write);
    step();
    check("idle_we", {31'd0, reg_write}, 32'd0);
    check("idle_hold_reg", {27'd0, write_reg}, 32'd5);

    // mul and fpu arrive together; mul first, then FPR f3
    mul_valid = 1; mul_rd = 5'd7; mul_data = 32'hAAAA;
    fpu_valid = 1; fpu_rd = 5'd3; fpu_data = 32'h3F800000; fpu_to_fpr = 1;
    step();
    mul_valid = 0; fpu_valid = 0;
    check("both_held_ready", {30'd0, mul_ready, fpu_ready}, 32'd0);
    check("both_held_we", {31'd0, reg_write}, 32'd0);
    step();
    check("rr_mul_we", {31'd0, reg_write}, 32'd1);
    check("rr_mul_reg", {27'd0, write_reg}, 32'd7);
    check("rr_mul_data", write_data, 32'hAAAA);
    check("rr_mul_sel", {31'd0, FPR_GPR_sel}, 32'd0);
    check("rr_mul_ready", {30'd0, mul_ready, fpu_ready}, 32'd2);
    $display("txn mul rd=7 data=0x%08h we=%0d", write_data, reg_write);
    step();
    check("rr_fpu_we", {31'd0, reg_write}, 32'd1);
    check("rr_fpu_reg", {27'd0, write_reg}, 32'd3);
    check("rr_fpu_data", write_data, 32'h3F800000);
    check("rr_fpu_sel", {31'd0, FPR_GPR_sel}, 32'd1);
    check("rr_ready_back", {30'd0, mul_ready, fpu_ready}, 32'd3);
    $display("txn fpu f3 data=0x%08h we=%0d", write_data, reg_write);
    step();
    check("rr_idle_we", {31'd0, reg_write}, 32'd0);

    // Starvation: int pipe hogs the port while mul waits
    mul_valid = 1; mul_rd = 5'd10; mul_data = 32'h55;
    step();
    mul_valid = 0;
    int_valid = 1; int_rd = 5'd1;
    for (int i = 0; i < 4; i++) begin
      int_data = 32'd100 + 32'(i);
      step();
      check("starve_int_data", write_data, 32'd100 + 32'(i));
      check("starve_stall", {31'd0, stall_int}, (i == 3) ? 32'd1 : 32'd0);
      check("starve_mul_ready", {31'd0, mul_ready}, 32'd0);
      $display("txn int starve cycle %0d data=%0d stall=%0d", i, write_data, stall_int);
    end
    int_valid = 0;
    step();
    check("starve_mul_we", {31'd0, reg_write}, 32'd1);
    check("starve_mul_reg", {27'd0, write_reg}, 32'd10);
    check("starve_mul_data", write_data, 32'h55);
    check("starve_stall_clear", {31'd0, stall_int}, 32'd0);
    check("starve_mul_ready_back", {31'd0, mul_ready}, 32'd1);
    $display("txn mul rd=10 after stall, stall=%0d", stall_int);
    step();

    // x0 rule: GPR x0 dropped, FPR f0 written
    int_valid = 1; int_rd = 5'd0; int_data = 32'hFFFF;
    step();
    int_valid = 0;
    check("x0_int_we", {31'd0, reg_write}, 32'd0);
    $display("txn int x0 dropped we=%0d", reg_write);
    fpu_valid = 1; fpu_rd = 5'd0; fpu_data = 32'hDEAD; fpu_to_fpr = 1;
    step();
    fpu_valid = 0;
    check("f0_capture_we", {31'd0, reg_write}, 32'd0);
    step();
    check("f0_we", {31'd0, reg_write}, 32'd1);
    check("f0_sel", {31'd0, FPR_GPR_sel}, 32'd1);
    check("f0_reg", {27'd0, write_reg}, 32'd0);
    check("f0_data", write_data, 32'hDEAD);
    $display("txn fpu f0 data=0x%08h we=%0d", write_data, reg_write);
    step();

`ifdef WB_PERF_EN
    check("perf_stall", perf_stall_cnt, 32'd1);
    check("perf_conflict", perf_conflict_cnt, 32'd5);
    check("perf_x0", perf_x0_drop_cnt, 32'd1);
    $display("txn perf stall=%0d conflict=%0d x0=%0d",
             perf_stall_cnt, perf_conflict_cnt, perf_x0_drop_cnt);
`endif

    // Reset while both entries are held
    mul_valid = 1; mul_rd = 5'd4; mul_data = 32'h4444;
    fpu_valid = 1; fpu_rd = 5'd6; fpu_data = 32'h6666; fpu_to_fpr = 0;
    step();
    mul_valid = 0; fpu_valid = 0;
    check("pre_rst_ready", {30'd0, mul_ready, fpu_ready}, 32'd0);
    rst = 1;
    step();
    rst = 0;
    check("mid_rst_we", {31'd0, reg_write}, 32'd0);
    check("mid_rst_reg", {27'd0, write_reg}, 32'd0);
    check("mid_rst_data", write_data, 32'd0);
    check("mid_rst_sel", {31'd0, FPR_GPR_sel}, 32'd0);
    check("mid_rst_stall", {31'd0, stall_int}, 32'd0);
    check("mid_rst_ready", {30'd0, mul_ready, fpu_ready}, 32'd3);
    $display("txn reset with held entries, ready=%0d%0d", mul_ready, fpu_ready);
    for (int i = 0; i < 4; i++) begin
      step();
      check("dropped_no_write", {31'd0, reg_write}, 32'd0);
    end
`ifdef WB_PERF_EN
    check("perf_rst_stall", perf_stall_cnt, 32'd0);
    check("perf_rst_conflict", perf_conflict_cnt, 32'd0);
    check("perf_rst_x0", perf_x0_drop_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
